// File: rtl/nibble_adder_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, FSM encoding
// and a constant-function log2 used to size the nibble index.
package nibble_adder_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rc_adder.sv
// Purely combinational 4-bit ripple-carry adder stage.
module rc_adder
    import nibble_adder_pkg::*;
(
    input  logic [NIB_W-1:0] x,
    input  logic [NIB_W-1:0] y,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic w_c1;
    logic w_c2;
    logic w_c3;

    assign s[0] = x[0] ^ y[0] ^ cin;
    assign w_c1 = (x[0] & y[0]) | (x[0] & cin) | (y[0] & cin);
    assign s[1] = x[1] ^ y[1] ^ w_c1;
    assign w_c2 = (x[1] & y[1]) | (x[1] & w_c1) | (y[1] & w_c1);
    assign s[2] = x[2] ^ y[2] ^ w_c2;
    assign w_c3 = (x[2] & y[2]) | (x[2] & w_c2) | (y[2] & w_c2);
    assign s[3] = x[3] ^ y[3] ^ w_c3;
    assign cout = (x[3] & y[3]) | (x[3] & w_c3) | (y[3] & w_c3);

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that streams operands through one rc_adder, LS nibble first.
// Optional subtract mode (sub port) when NIBBLE_SERIAL_SUB_EN is defined.
module nibble_serial_adder
    import nibble_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NIBBLE_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned NIB   = WIDTH / NIB_W;
    localparam int unsigned IDX_W = (NIB > 1) ? clog2(NIB) : 1;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_out_valid;

    logic [NIB_W-1:0]   w_x;
    logic [NIB_W-1:0]   w_y;
    logic [NIB_W-1:0]   w_s;
    logic               w_c;

    // Select the current operand nibbles for the shared adder stage.
    always_comb begin
        w_x = '0;
        w_y = '0;
        for (int i = 0; i < int'(NIB); i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_x = r_a[i*NIB_W +: NIB_W];
                w_y = r_b[i*NIB_W +: NIB_W];
            end
        end
    end

    rc_adder u_rc_adder (
        .x    (w_x),
        .y    (w_y),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a   <= a;
                        r_idx <= '0;
`ifdef NIBBLE_SERIAL_SUB_EN
                        // Subtract as a + ~b + 1; cin is ignored in this mode.
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
`else
                        r_b     <= b;
                        r_carry <= cin;
`endif
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < int'(NIB); i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            r_sum[i*NIB_W +: NIB_W] <= w_s;
                        end
                    end
                    r_carry <= w_c;
                    // Index stops at the last nibble rather than wrapping.
                    if (r_idx == IDX_W'(NIB - 1)) begin
                        r_cout      <= w_c;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_RUN);
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder (WIDTH=16).
`timescale 1ns/1ps
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub_i;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;

    int n_checks;
    int n_errors;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef NIBBLE_SERIAL_SUB_EN
        .sub       (sub_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op with out_ready=1 and check latency, result and return to IDLE.
    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vcin, input logic vsub,
                          input logic [15:0] exp_sum, input logic exp_cout);
        int lat;
        @(negedge clk);
        a = va; b = vb; cin = vcin; sub_i = vsub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
        @(posedge clk); #1;
        check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'h0000);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        run_op("basic",   16'h5A5A, 16'hA5A5, 1'b0, 1'b0, 16'hFFFF, 1'b0);
        run_op("ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        run_op("cin_only",16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0);
        run_op("top_cy",  16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1);

        // Backpressure: result held while out_ready is low; extra request ignored.
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub_i = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd4);
        for (int k = 0; k < 6; k++) begin
            if (k == 2) begin
                a = 16'h7777; b = 16'h7777; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_sum", 32'(sum), 32'h2345);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_sum_kept", 32'(sum), 32'h2345);
        @(posedge clk); #1;
        check("bp_no_second_op", 32'(busy), 32'd0);

        // Reset during RUN aborts the op without an out_valid pulse.
        @(negedge clk);
        a = 16'h0F0F; b = 16'h0101; cin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_sum", 32'(sum), 32'h0000);
        repeat (4) begin
            @(posedge clk); #1;
            check("abort_no_pulse", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_idle", 32'(in_ready), 32'd1);
        run_op("post_abort", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0);

`ifdef NIBBLE_SERIAL_SUB_EN
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0);
        run_op("sub_ok",     16'h0009, 16'h0002, 1'b0, 1'b1, 16'h0007, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
